// File: rtl/bram_pixel_reader.sv
// Linear frame scanner: fetches R/G/B planes from a 1-cycle BRAM and streams packed RGB pixels.
// Optional PIXEL_GRAY_EN macro adds a registered 8-bit luma-ish pix_gray output.
module bram_pixel_reader #(
    parameter int unsigned IMG_W  = 320,
    parameter int unsigned IMG_H  = 240,
    parameter int unsigned ADDR_W = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [1:0]        mem_channel,
    input  logic [7:0]        mem_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [23:0]       pix_rgb,
    output logic              pix_sof,
`ifdef PIXEL_GRAY_EN
    output logic              pix_last,
    output logic [7:0]        pix_gray
`else
    output logic              pix_last
`endif
);

    localparam int unsigned       NumPix   = IMG_W * IMG_H;
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NumPix - 1);

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StReqR = 3'd1;
    localparam logic [2:0] StReqG = 3'd2;
    localparam logic [2:0] StReqB = 3'd3;
    localparam logic [2:0] StCapB = 3'd4;
    localparam logic [2:0] StOut  = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        r_q, r_d;
    logic [7:0]        g_q, g_d;
    logic [23:0]       rgb_q, rgb_d;
    logic              valid_q, valid_d;
    logic              sof_q, sof_d;
    logic              last_q, last_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
`ifdef PIXEL_GRAY_EN
    logic [7:0]        gray_q, gray_d;
    logic [9:0]        gray_sum;

    assign gray_sum = {2'b00, r_q} + {1'b0, g_q, 1'b0} + {2'b00, mem_data};
`endif

    // Channel presented one cycle ahead of the capture state because the BRAM read is registered.
    always_comb begin
        case (state_q)
            StReqG:  mem_channel = 2'b10;
            StReqB:  mem_channel = 2'b11;
            default: mem_channel = 2'b01;
        endcase
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        r_d     = r_q;
        g_d     = g_q;
        rgb_d   = rgb_q;
        valid_d = valid_q;
        sof_d   = sof_q;
        last_d  = last_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef PIXEL_GRAY_EN
        gray_d  = gray_q;
`endif
        if (abort) begin
            if (state_q != StIdle) begin
                state_d = StIdle;
                valid_d = 1'b0;
                busy_d  = 1'b0;
                addr_d  = '0;
            end
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_d = StReqR;
                        addr_d  = '0;
                        busy_d  = 1'b1;
                    end
                end
                StReqR: state_d = StReqG;
                StReqG: begin
                    r_d     = mem_data;
                    state_d = StReqB;
                end
                StReqB: begin
                    g_d     = mem_data;
                    state_d = StCapB;
                end
                StCapB: begin
                    rgb_d   = {r_q, g_q, mem_data};
                    sof_d   = (addr_q == '0);
                    last_d  = (addr_q == LastAddr);
                    valid_d = 1'b1;
`ifdef PIXEL_GRAY_EN
                    gray_d  = gray_sum[9:2];
`endif
                    state_d = StOut;
                end
                StOut: begin
                    if (pix_ready) begin
                        valid_d = 1'b0;
                        if (last_q) begin
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            state_d = StIdle;
                        end else begin
                            addr_d  = addr_q + ADDR_W'(1);
                            state_d = StReqR;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            r_q     <= '0;
            g_q     <= '0;
            rgb_q   <= '0;
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef PIXEL_GRAY_EN
            gray_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            r_q     <= r_d;
            g_q     <= g_d;
            rgb_q   <= rgb_d;
            valid_q <= valid_d;
            sof_q   <= sof_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef PIXEL_GRAY_EN
            gray_q  <= gray_d;
`endif
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign mem_addr  = addr_q;
    assign pix_valid = valid_q;
    assign pix_rgb   = rgb_q;
    assign pix_sof   = sof_q;
    assign pix_last  = last_q;
`ifdef PIXEL_GRAY_EN
    assign pix_gray  = gray_q;
`endif

endmodule

// File: tb/tb_bram_pixel_reader.sv
// Scoreboard bench for bram_pixel_reader on a 4x2 frame with a synthetic registered-read BRAM.
module tb_bram_pixel_reader;

    logic       clk = 1'b0;
    logic       rst, start, abort, pix_ready;
    logic       busy, done, pix_valid, pix_sof, pix_last;
    logic [2:0] mem_addr;
    logic [1:0] mem_channel;
    logic [7:0] mem_data;
    logic [23:0] pix_rgb;
`ifdef PIXEL_GRAY_EN
    logic [7:0] pix_gray;
    int         gray_mode = 0;
`endif

    int total = 0;
    int bad = 0;
    int hs_cnt = 0;
    int done_cnt = 0;
    logic [25:0] sb[$];
    logic        prev_stall = 1'b0;
    logic [26:0] prev_pix = '0;

    always #5 clk = ~clk;

    bram_pixel_reader #(
        .IMG_W(4),
        .IMG_H(2),
        .ADDR_W(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .abort(abort),
        .busy(busy),
        .done(done),
        .mem_addr(mem_addr),
        .mem_channel(mem_channel),
        .mem_data(mem_data),
        .pix_valid(pix_valid),
        .pix_ready(pix_ready),
        .pix_rgb(pix_rgb),
        .pix_sof(pix_sof),
`ifdef PIXEL_GRAY_EN
        .pix_last(pix_last),
        .pix_gray(pix_gray)
`else
        .pix_last(pix_last)
`endif
    );

    // BRAM model: R=addr, G=addr+16, B=addr+32, one-cycle registered read
    always @(posedge clk) begin
`ifdef PIXEL_GRAY_EN
        if (gray_mode == 1)
            mem_data <= (mem_channel == 2'b01) ? 8'd200 : (mem_channel == 2'b10) ? 8'd100 : 8'd50;
        else if (gray_mode == 2)
            mem_data <= 8'd255;
        else
`endif
        case (mem_channel)
            2'b10:   mem_data <= 8'(mem_addr) + 8'd16;
            2'b11:   mem_data <= 8'(mem_addr) + 8'd32;
            default: mem_data <= 8'(mem_addr);
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted pixel, checks stall stability
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_stall)
                chk("hold", {5'd0, pix_valid, pix_rgb, pix_sof, pix_last}, {5'd0, prev_pix});
            if (pix_valid && pix_ready && !abort) begin
                hs_cnt++;
                if (sb.size() == 0) chk("hs_unexpected", {31'd0, pix_valid}, 32'd0);
                else chk("pixel", {6'd0, pix_rgb, pix_sof, pix_last}, {6'd0, sb.pop_front()});
            end
            if (done) done_cnt++;
        end
        prev_stall = pix_valid && !pix_ready && !abort && !rst;
        prev_pix   = {pix_valid, pix_rgb, pix_sof, pix_last};
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame;
        for (int k = 0; k < 8; k++)
            sb.push_back({8'(k), 8'(k + 16), 8'(k + 32), (k == 0), (k == 7)});
        hs_cnt   = 0;
        done_cnt = 0;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_addr(input int a);
        int n = 0;
        while (int'(mem_addr) != a && n < 200) begin
            tick();
            n++;
        end
        chk("wait_addr", {29'd0, mem_addr}, a);
    endtask

    task automatic wait_valid;
        int n = 0;
        while (!pix_valid && n < 200) begin
            tick();
            n++;
        end
        chk("wait_valid", {31'd0, pix_valid}, 32'd1);
    endtask

    task automatic wait_done;
        int n = 0;
        while (!done && n < 400) begin
            tick();
            n++;
        end
        chk("wait_done", {31'd0, done}, 32'd1);
        tick();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_valid"}, {31'd0, pix_valid}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_addr"}, {29'd0, mem_addr}, 32'd0);
        chk({tag, "_chan"}, {30'd0, mem_channel}, 32'd1);
        chk({tag, "_rgb"}, {8'd0, pix_rgb}, 32'd0);
        chk({tag, "_soflast"}, {30'd0, pix_sof, pix_last}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; pix_ready = 1'b1;
        repeat (2) tick();
        chk_reset_vals("rst");
        rst = 1'b0;
        tick();

        // 1: free-running frame, latency 5, spacing 5, done after last
        push_frame();
        pulse_start();
        chk("t1_busy", {31'd0, busy}, 32'd1);
        chk("t1_v0", {31'd0, pix_valid}, 32'd0);
        repeat (3) tick();
        chk("t1_lat_early", {31'd0, pix_valid}, 32'd0);
        tick();
        chk("t1_lat_first", {31'd0, pix_valid}, 32'd1);
        chk("t1_first", {6'd0, pix_rgb, pix_sof, pix_last}, {6'd0, 24'h001020, 2'b10});
        for (int k = 1; k < 8; k++) begin
            repeat (4) tick();
            chk("t1_gap", {31'd0, pix_valid}, 32'd0);
            tick();
            chk("t1_spacing", {31'd0, pix_valid}, 32'd1);
            chk("t1_addr", {29'd0, mem_addr}, k);
        end
        chk("t1_last", {30'd0, pix_sof, pix_last}, 32'd1);
        tick();
        chk("t1_done", {30'd0, done, busy}, 32'd2);
        tick();
        chk("t1_done_pulse", {31'd0, done}, 32'd0);
        chk("t1_hs", hs_cnt, 32'd8);
        chk("t1_done_cnt", done_cnt, 32'd1);
        chk("t1_sb", sb.size(), 32'd0);

        // 2: back-pressure on pixel 3
        push_frame();
        pulse_start();
        wait_addr(3);
        pix_ready = 1'b0;
        wait_valid();
        for (int i = 0; i < 10; i++) begin
            chk("t2_stall", {4'd0, pix_valid, pix_rgb, mem_addr}, {4'd0, 1'b1, 24'h031323, 3'd3});
            tick();
        end
        pix_ready = 1'b1;
        wait_done();
        chk("t2_hs", hs_cnt, 32'd8);
        chk("t2_done_cnt", done_cnt, 32'd1);
        chk("t2_sb", sb.size(), 32'd0);

        // 3: start re-pulsed mid-frame is ignored
        push_frame();
        pulse_start();
        wait_addr(2);
        pulse_start();
        wait_done();
        chk("t3_hs", hs_cnt, 32'd8);
        chk("t3_done_cnt", done_cnt, 32'd1);
        chk("t3_busy", {31'd0, busy}, 32'd0);

        // 4: synchronous reset during pixel 4 fetch, then restart
        push_frame();
        pulse_start();
        wait_addr(4);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_vals("t4");
        chk("t4_hs", hs_cnt, 32'd4);
        sb.delete();
        repeat (6) tick();
        chk("t4_no_done", done_cnt, 32'd0);
        push_frame();
        pulse_start();
        wait_valid();
        chk("t4_restart", {28'd0, mem_addr, pix_sof}, 32'd1);
        wait_done();
        chk("t4_hs2", hs_cnt, 32'd8);
        chk("t4_sb", sb.size(), 32'd0);

        // 5: abort wins over a handshake in the same cycle
        push_frame();
        pulse_start();
        wait_addr(2);
        wait_valid();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t5_state", {28'd0, pix_valid, busy, done, 1'b0}, 32'd0);
        chk("t5_addr", {29'd0, mem_addr}, 32'd0);
        chk("t5_hs", hs_cnt, 32'd2);
        sb.delete();
        repeat (8) tick();
        chk("t5_no_done", done_cnt, 32'd0);
        chk("t5_idle", {31'd0, pix_valid}, 32'd0);
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("t5_abort_start", {31'd0, busy}, 32'd0);
        repeat (6) tick();
        chk("t5_abort_start_v", {31'd0, pix_valid}, 32'd0);

`ifdef PIXEL_GRAY_EN
        // 6: gray output
        gray_mode = 1;
        pulse_start();
        wait_valid();
        chk("t6_gray112", {24'd0, pix_gray}, 32'd112);
        chk("t6_rgb", {8'd0, pix_rgb}, 32'hC86432);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        gray_mode = 2;
        pulse_start();
        wait_valid();
        chk("t6_gray255", {24'd0, pix_gray}, 32'd255);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        gray_mode = 0;
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
